// File: rtl/context_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// context_scheduler_pkg
// Shared definitions for the time-slice context scheduler: FSM state type,
// default address constants and the reset-PC helper for the saved-PC table.
// ---------------------------------------------------------------------------
package context_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SWITCH  = 2'd2,
        ST_HANDLER = 2'd3
    } sched_state_e;

    localparam int PC_W         = 12;
    localparam int BOOT_ADDR    = 256;
    localparam int HANDLER_ADDR = 1083;

    // Reset PC of a slot before truncation to the PC width.
    function automatic int slot_boot_pc(input int boot, input int stride, input int slot);
        return boot + slot * stride;
    endfunction

endpackage

// File: rtl/context_scheduler_if.sv
// ---------------------------------------------------------------------------
// context_scheduler_if
// Bundles the scheduler's control/status signals.
//   master : control side (drives sched_enable, quantum, proc_ready,
//            programCounter, HLT, handler_done; observes the rest)
//   slave  : the scheduler itself
// Outputs of the scheduler: jump_context_exchange, current_proc, next_proc,
// restore_pc, in_handler, switch_count.
// ---------------------------------------------------------------------------
interface context_scheduler_if #(
    parameter int NUM_PROCS = 4,
    parameter int PC_W      = context_scheduler_pkg::PC_W,
    parameter int Q_W       = 16
);
    localparam int IDX_W = $clog2(NUM_PROCS);

    logic                 sched_enable;
    logic [Q_W-1:0]       quantum;
    logic [NUM_PROCS-1:0] proc_ready;
    logic [PC_W-1:0]      programCounter;
    logic                 HLT;
    logic                 handler_done;
    logic                 jump_context_exchange;
    logic [IDX_W-1:0]     current_proc;
    logic [IDX_W-1:0]     next_proc;
    logic [PC_W-1:0]      restore_pc;
    logic                 in_handler;
    logic [15:0]          switch_count;

    modport master (
        output sched_enable, quantum, proc_ready, programCounter, HLT, handler_done,
        input  jump_context_exchange, current_proc, next_proc, restore_pc,
               in_handler, switch_count
    );

    modport slave (
        input  sched_enable, quantum, proc_ready, programCounter, HLT, handler_done,
        output jump_context_exchange, current_proc, next_proc, restore_pc,
               in_handler, switch_count
    );

endinterface

// File: rtl/context_scheduler_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Scans the slots after i_current,
// wrapping, and returns the first ready one. The current slot is never a
// candidate.
//   i_ready      ready mask, one bit per slot
//   i_current    running slot
//   o_winner     first ready slot after i_current (i_current if none)
//   o_any_other  1 when some slot other than i_current is ready
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter  int NUM_PROCS = 4,
    localparam int IDX_W     = $clog2(NUM_PROCS)
) (
    input  logic [NUM_PROCS-1:0] i_ready,
    input  logic [IDX_W-1:0]     i_current,
    output logic [IDX_W-1:0]     o_winner,
    output logic                 o_any_other
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_winner    = i_current;
        o_any_other = 1'b0;
        w_idx       = '0;
        for (int k = 1; k < NUM_PROCS; k++) begin
            w_idx = IDX_W'((int'(i_current) + k) % NUM_PROCS);
            if (!o_any_other && i_ready[w_idx]) begin
                o_winner    = w_idx;
                o_any_other = 1'b1;
            end
        end
    end

endmodule

// File: rtl/context_scheduler.sv
// ---------------------------------------------------------------------------
// context_scheduler
// Time-slice scheduler beside the PC block. Counts a quantum while a process
// runs, pulses jump_context_exchange for one cycle to enter the kernel
// handler, saves the preempted PC and selects the next ready slot
// round-robin, exposing that slot's saved PC on restore_pc.
// Ports:
//   clock       rising-edge clock
//   resetCPU_n  asynchronous active-low reset
//   bus         context_scheduler_if.slave (all control/status signals)
// ---------------------------------------------------------------------------
module context_scheduler #(
    parameter int NUM_PROCS   = 4,
    parameter int PC_W        = context_scheduler_pkg::PC_W,
    parameter int Q_W         = 16,
    parameter int BOOT_ADDR   = context_scheduler_pkg::BOOT_ADDR,
    parameter int PROC_STRIDE = 64
) (
    input  logic               clock,
    input  logic               resetCPU_n,
    context_scheduler_if.slave bus
);
    import context_scheduler_pkg::*;

    localparam int IDX_W = $clog2(NUM_PROCS);

    sched_state_e     r_state, w_state_nxt;
    logic [Q_W-1:0]   r_count, w_count_nxt, w_limit;
    logic [IDX_W-1:0] r_current, r_next, w_winner;
    logic             w_any_other, w_expired;
    logic [PC_W-1:0]  r_saved_pc [NUM_PROCS];
    logic [PC_W-1:0]  r_restore_pc;
    logic [15:0]      r_switch_count;

    // A quantum of 0 behaves as 1, so the last counted value is max(q,1)-1.
    assign w_limit   = (bus.quantum == '0) ? '0 : bus.quantum - Q_W'(1);
    assign w_expired = (r_count >= w_limit) || !bus.proc_ready[r_current];

    rr_picker #(.NUM_PROCS(NUM_PROCS)) u_rr_picker (
        .i_ready     (bus.proc_ready),
        .i_current   (r_current),
        .o_winner    (w_winner),
        .o_any_other (w_any_other)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                if (bus.sched_enable) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.sched_enable) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else if (w_expired) begin
                    // With nobody else runnable the slice simply restarts.
                    if (w_any_other) w_state_nxt = ST_SWITCH;
                    else             w_count_nxt = '0;
                end else if (!bus.HLT) begin
                    w_count_nxt = r_count + Q_W'(1);
                end
            end
            ST_SWITCH: w_state_nxt = ST_HANDLER;
            ST_HANDLER: begin
                // No timeout: the PC block's long stall is absorbed here.
                if (bus.handler_done) begin
                    w_count_nxt = '0;
                    w_state_nxt = bus.sched_enable ? ST_RUN : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetCPU_n) begin
        if (!resetCPU_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetCPU_n) begin
        if (!resetCPU_n) begin
            r_current      <= '0;
            r_next         <= '0;
            r_switch_count <= '0;
            r_restore_pc   <= PC_W'(BOOT_ADDR);
            for (int i = 0; i < NUM_PROCS; i++) begin
                r_saved_pc[i] <= PC_W'(slot_boot_pc(BOOT_ADDR, PROC_STRIDE, i));
            end
        end else begin
            // Registered lookup: follows next_proc with one cycle of latency.
            r_restore_pc <= r_saved_pc[r_next];
            if (r_state == ST_SWITCH) begin
                r_saved_pc[r_current] <= bus.programCounter;
                r_next                <= w_winner;
            end
            if (r_state == ST_HANDLER && bus.handler_done) begin
                r_current      <= r_next;
                r_switch_count <= r_switch_count + 16'd1;
            end
        end
    end

    assign bus.jump_context_exchange = (r_state == ST_SWITCH);
    assign bus.in_handler            = (r_state == ST_SWITCH) || (r_state == ST_HANDLER);
    assign bus.current_proc          = r_current;
    assign bus.next_proc             = r_next;
    assign bus.restore_pc            = r_restore_pc;
    assign bus.switch_count          = r_switch_count;

endmodule

// File: tb/tb_context_scheduler.sv
module tb_context_scheduler;

    logic clock = 1'b0;
    logic resetCPU_n;

    always #5 clock = ~clock;

    context_scheduler_if #(.NUM_PROCS(4), .PC_W(12), .Q_W(16)) bus ();

    context_scheduler #(
        .NUM_PROCS(4), .PC_W(12), .Q_W(16), .BOOT_ADDR(256), .PROC_STRIDE(64)
    ) dut (
        .clock      (clock),
        .resetCPU_n (resetCPU_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the scheduler should know at the abstract level.
    logic [11:0] m_saved [4];
    int          m_current;
    int          m_next;
    int          m_sc;
    bit          m_in_handler;

    function automatic int rr_pick(input logic [3:0] rdy, input int cur);
        for (int k = 1; k < 4; k++) begin
            int s;
            s = (cur + k) % 4;
            if (((rdy >> s) & 4'd1) != 4'd0) return s;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_saved[i] = 12'((256 + 64 * i) % 4096);
        m_current    = 0;
        m_next       = 0;
        m_sc         = 0;
        m_in_handler = 0;
    endtask

    task automatic apply_reset();
        resetCPU_n         = 1'b0;
        bus.sched_enable   = 1'b0;
        bus.quantum        = 16'd1;
        bus.proc_ready     = 4'b0001;
        bus.programCounter = 12'd0;
        bus.HLT            = 1'b0;
        bus.handler_done   = 1'b0;
        repeat (2) step();
        resetCPU_n = 1'b1;
        step();
        model_reset();
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (bus.jump_context_exchange !== 1'b0 || bus.in_handler !== 1'b0) begin
            n_errors++;
            $display("FAIL %s flags: jump=%b in_handler=%b required 0/0", tag,
                     bus.jump_context_exchange, bus.in_handler);
        end
        n_checks++;
        if (bus.current_proc !== 2'd0 || bus.next_proc !== 2'd0 || bus.switch_count !== 16'd0) begin
            n_errors++;
            $display("FAIL %s procs: current=%0d next=%0d count=%0d required 0/0/0", tag,
                     bus.current_proc, bus.next_proc, bus.switch_count);
        end
        n_checks++;
        if (bus.restore_pc !== 12'd256) begin
            n_errors++;
            $display("FAIL %s restore_pc: got %0d required 256", tag, bus.restore_pc);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dut.r_saved_pc[i] !== m_saved[i]) begin
                n_errors++;
                $display("FAIL %s saved_pc[%0d]: got %0d required %0d", tag, i,
                         dut.r_saved_pc[i], m_saved[i]);
            end
        end
    endtask

    // Runs one slice ending in a switch. Starts from IDLE or, when the model
    // says a handler is pending, completes it with handler_done first.
    task automatic run_switch(input int q, input logic [3:0] rdy, input int hlt_from,
                              input int hlt_len, input bit stray, input string tag);
        int          run_cycles, exp_edges, edges, win, prev_cur, hl;
        bit          seen;
        logic [11:0] pc_at;
        bus.quantum      = 16'(q);
        bus.proc_ready   = rdy;
        bus.sched_enable = 1'b1;
        if (m_in_handler) begin
            bus.handler_done = 1'b1;
            m_current        = m_next;
            m_sc             = (m_sc + 1) % 65536;
            m_in_handler     = 0;
        end
        if (((rdy >> m_current) & 4'd1) != 4'd0) begin
            run_cycles = (q < 1) ? 1 : q;
            hl         = hlt_len;
        end else begin
            run_cycles = 1;
            hl         = 0;
        end
        exp_edges = 1 + run_cycles + hl;
        win       = rr_pick(rdy, m_current);
        prev_cur  = m_current;
        edges     = 0;
        seen      = 0;
        pc_at     = '0;
        while (!seen && edges < exp_edges + 20) begin
            step();
            edges++;
            if (edges == 1) begin
                n_checks++;
                if (bus.current_proc !== 2'(m_current) || bus.switch_count !== 16'(m_sc)
                    || bus.in_handler !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s slice_start: current=%0d count=%0d in_handler=%b required %0d/%0d/0",
                             tag, bus.current_proc, bus.switch_count, bus.in_handler, m_current, m_sc);
                end
            end
            bus.handler_done   = stray && (edges == 1);
            bus.HLT            = (hl > 0) && (edges >= hlt_from) && (edges < hlt_from + hl);
            bus.programCounter = 12'($urandom);
            if (bus.jump_context_exchange === 1'b1) begin
                seen  = 1;
                pc_at = bus.programCounter;
            end
        end
        bus.HLT          = 1'b0;
        bus.handler_done = 1'b0;
        n_checks++;
        if (!seen || edges != exp_edges) begin
            n_errors++;
            $display("FAIL %s pulse_time: seen=%0d after %0d cycles required after %0d cycles",
                     tag, seen, edges, exp_edges);
        end
        n_checks++;
        if (bus.in_handler !== 1'b1) begin
            n_errors++;
            $display("FAIL %s in_handler_at_pulse: got %b required 1", tag, bus.in_handler);
        end
        step();
        n_checks++;
        if (bus.jump_context_exchange !== 1'b0 || bus.next_proc !== 2'(win) || bus.in_handler !== 1'b1) begin
            n_errors++;
            $display("FAIL %s after_pulse: jump=%b next=%0d in_handler=%b required 0/%0d/1",
                     tag, bus.jump_context_exchange, bus.next_proc, bus.in_handler, win);
        end
        m_saved[prev_cur] = pc_at;
        m_next            = win;
        m_in_handler      = 1;
        step();
        n_checks++;
        if (bus.restore_pc !== m_saved[win]) begin
            n_errors++;
            $display("FAIL %s restore_pc: got %0d required %0d", tag, bus.restore_pc, m_saved[win]);
        end
        n_checks++;
        if (dut.r_saved_pc[prev_cur] !== pc_at) begin
            n_errors++;
            $display("FAIL %s saved_pc[%0d]: got %0d required %0d", tag, prev_cur,
                     dut.r_saved_pc[prev_cur], pc_at);
        end
        // Kernel busy for a while; HLT toggling here must not matter.
        for (int i = 0; i < int'($urandom_range(2, 10)); i++) begin
            bus.HLT = 1'($urandom);
            step();
            n_checks++;
            if (bus.in_handler !== 1'b1 || bus.jump_context_exchange !== 1'b0) begin
                n_errors++;
                $display("FAIL %s handler_wait: in_handler=%b jump=%b required 1/0", tag,
                         bus.in_handler, bus.jump_context_exchange);
            end
        end
        bus.HLT = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        check_reset_values("reset");
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (dut.r_count !== 16'd0 || bus.jump_context_exchange !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle: count=%0d jump=%b required 0/0", dut.r_count,
                         bus.jump_context_exchange);
            end
        end
    endtask

    task automatic test_basic_switch();
        apply_reset();
        run_switch(10, 4'b0011, 0, 0, 1'b0, "basic");
        n_checks++;
        if (bus.restore_pc !== 12'd320 || bus.next_proc !== 2'd1) begin
            n_errors++;
            $display("FAIL basic_target: restore=%0d next=%0d required 320/1", bus.restore_pc,
                     bus.next_proc);
        end
    endtask

    task automatic test_hlt();
        run_switch(10, 4'b0011, 3, 7, 1'b0, "hlt");
    endtask

    task automatic test_no_other();
        apply_reset();
        bus.quantum      = 16'd5;
        bus.proc_ready   = 4'b0001;
        bus.sched_enable = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            step();
            n_checks++;
            if (bus.jump_context_exchange !== 1'b0 || dut.r_count !== 16'((n - 1) % 5)) begin
                n_errors++;
                $display("FAIL no_other cycle %0d: jump=%b count=%0d required 0/%0d", n,
                         bus.jump_context_exchange, dut.r_count, (n - 1) % 5);
            end
        end
        bus.sched_enable = 1'b0;
        step();
        n_checks++;
        if (dut.r_count !== 16'd0 || bus.in_handler !== 1'b0) begin
            n_errors++;
            $display("FAIL no_other_disable: count=%0d in_handler=%b required 0/0", dut.r_count,
                     bus.in_handler);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_switch(int'($urandom_range(1, 8)), 4'b1111, 0, 0, 1'b1, "wrap");
        end
        n_checks++;
        if (bus.current_proc !== 2'd3 || bus.next_proc !== 2'd0) begin
            n_errors++;
            $display("FAIL wrap_winner: current=%0d next=%0d required 3/0", bus.current_proc,
                     bus.next_proc);
        end
        // handler_done promotes slot 0 and bumps the counter.
        run_switch(3, 4'b1111, 0, 0, 1'b0, "wrap_done");
        n_checks++;
        if (bus.current_proc !== 2'd0 || bus.switch_count !== 16'd4) begin
            n_errors++;
            $display("FAIL wrap_done: current=%0d count=%0d required 0/4", bus.current_proc,
                     bus.switch_count);
        end
    endtask

    task automatic test_quantum_zero();
        apply_reset();
        run_switch(0, 4'b0011, 0, 0, 1'b1, "quantum0");
    endtask

    task automatic test_disable_in_handler();
        bus.sched_enable = 1'b0;
        repeat (5) step();
        n_checks++;
        if (bus.in_handler !== 1'b1) begin
            n_errors++;
            $display("FAIL dis_handler_hold: in_handler=%b required 1", bus.in_handler);
        end
        bus.handler_done = 1'b1;
        step();
        bus.handler_done = 1'b0;
        m_current    = m_next;
        m_sc         = (m_sc + 1) % 65536;
        m_in_handler = 0;
        n_checks++;
        if (bus.in_handler !== 1'b0 || bus.current_proc !== 2'(m_current)
            || bus.switch_count !== 16'(m_sc)) begin
            n_errors++;
            $display("FAIL dis_handler_done: in_handler=%b current=%0d count=%0d required 0/%0d/%0d",
                     bus.in_handler, bus.current_proc, bus.switch_count, m_current, m_sc);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (bus.jump_context_exchange !== 1'b0 || dut.r_count !== 16'd0) begin
                n_errors++;
                $display("FAIL dis_idle: jump=%b count=%0d required 0/0",
                         bus.jump_context_exchange, dut.r_count);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int          cur_eff, other, q, hf, hl;
            logic [3:0]  rdy;
            cur_eff = m_in_handler ? m_next : m_current;
            other   = (cur_eff + int'($urandom_range(1, 3))) % 4;
            rdy     = 4'($urandom) | 4'(1 << other);
            q       = int'($urandom_range(0, 12));
            hf      = 0;
            hl      = 0;
            if (q >= 3 && $urandom_range(0, 1) == 1) begin
                hf = int'($urandom_range(1, q - 1));
                hl = int'($urandom_range(1, 5));
            end
            run_switch(q, rdy, hf, hl, 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_in_handler();
        @(posedge clock);
        #3;
        resetCPU_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_reset");
        bus.sched_enable = 1'b0;
        bus.handler_done = 1'b0;
        step();
        resetCPU_n = 1'b1;
        step();
        check_reset_values("after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_switch();
        test_hlt();
        test_disable_in_handler();
        test_no_other();
        test_wrap();
        test_quantum_zero();
        test_random();
        test_reset_in_handler();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
